// File: rtl/podium_permutation_gen.sv
// Enumerates the 24 permutations of {0,1,2,3} in lexicographic order over VALID/READY.
// Define PODIUM_GEN_IMAP_EN to register the inverse map on IMAP; otherwise IMAP is 8'h00.
module podium_permutation_gen #(
   parameter int WRAP = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ABORT,
   input  logic       READY,
   output logic       VALID,
   output logic [1:0] N0,
   output logic [1:0] N1,
   output logic [1:0] N2,
   output logic [1:0] N3,
   output logic [4:0] RANK,
   output logic [7:0] IMAP,
   output logic       DONE
);

   typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

   // Permutations are packed as {N3,N2,N1,N0}; identity also equals its own inverse.
   localparam logic [7:0] IDENT     = 8'b11_10_01_00;
   localparam logic [4:0] RANK_LAST = 5'd23;

   state_t     state_p0, state_nxt;
   logic [7:0] perm_p0, perm_nxt;
   logic [4:0] rank_p0, rank_nxt;
   logic       vld_p0, vld_nxt;
   logic       done_p0, done_nxt;

   // Pivot i is the largest index with p[i] < p[i+1]; the tail after it is descending.
   function automatic logic [7:0] next_perm(input logic [7:0] cur);
      logic [1:0] p0, p1, p2, p3;
      p0 = cur[1:0];
      p1 = cur[3:2];
      p2 = cur[5:4];
      p3 = cur[7:6];
      if (p2 < p3) begin
         {p2, p3} = {p3, p2};
      end else if (p1 < p2) begin
         if (p3 > p1) {p1, p3} = {p3, p1};
         else         {p1, p2} = {p2, p1};
         {p2, p3} = {p3, p2};
      end else if (p0 < p1) begin
         if      (p3 > p0) {p0, p3} = {p3, p0};
         else if (p2 > p0) {p0, p2} = {p2, p0};
         else              {p0, p1} = {p1, p0};
         {p1, p3} = {p3, p1};
      end
      return {p3, p2, p1, p0};
   endfunction

   always_comb begin
      state_nxt = state_p0;
      perm_nxt  = perm_p0;
      rank_nxt  = rank_p0;
      vld_nxt   = vld_p0;
      done_nxt  = 1'b0;
      if (ABORT) begin
         state_nxt = IDLE;
         perm_nxt  = IDENT;
         rank_nxt  = '0;
         vld_nxt   = 1'b0;
      end else begin
         case (state_p0)
            IDLE: begin
               if (START) begin
                  state_nxt = RUN;
                  perm_nxt  = IDENT;
                  rank_nxt  = '0;
                  vld_nxt   = 1'b1;
               end
            end
            RUN: begin
               if (vld_p0 && READY) begin
                  if (rank_p0 != RANK_LAST) begin
                     perm_nxt = next_perm(perm_p0);
                     rank_nxt = rank_p0 + 5'd1;
                  end else if (WRAP != 0) begin
                     perm_nxt = IDENT;
                     rank_nxt = '0;
                  end else begin
                     // Park data at reset values so IDLE always looks the same.
                     state_nxt = LAST;
                     perm_nxt  = IDENT;
                     rank_nxt  = '0;
                     vld_nxt   = 1'b0;
                     done_nxt  = 1'b1;
                  end
               end
            end
            LAST: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               perm_nxt  = IDENT;
               rank_nxt  = '0;
               vld_nxt   = 1'b0;
            end
         endcase
      end
   end

   // Output register stage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_p0 <= IDLE;
         perm_p0  <= IDENT;
         rank_p0  <= '0;
         vld_p0   <= 1'b0;
         done_p0  <= 1'b0;
      end else begin
         state_p0 <= state_nxt;
         perm_p0  <= perm_nxt;
         rank_p0  <= rank_nxt;
         vld_p0   <= vld_nxt;
         done_p0  <= done_nxt;
      end
   end

`ifdef PODIUM_GEN_IMAP_EN
   logic [7:0] imap_p0;

   function automatic logic [1:0] pos_of(input logic [7:0] p, input logic [1:0] v);
      if      (p[1:0] == v) return 2'd0;
      else if (p[3:2] == v) return 2'd1;
      else if (p[5:4] == v) return 2'd2;
      else                  return 2'd3;
   endfunction

   // Derived from the next-state tuple so it lands in the same cycle as N0..N3.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) imap_p0 <= IDENT;
      else     imap_p0 <= {pos_of(perm_nxt, 2'd3), pos_of(perm_nxt, 2'd2),
                           pos_of(perm_nxt, 2'd1), pos_of(perm_nxt, 2'd0)};
   end

   assign IMAP = imap_p0;
`else
   assign IMAP = 8'h00;
`endif

   assign VALID = vld_p0;
   assign DONE  = done_p0;
   assign RANK  = rank_p0;
   assign N0    = perm_p0[1:0];
   assign N1    = perm_p0[3:2];
   assign N2    = perm_p0[5:4];
   assign N3    = perm_p0[7:6];

endmodule
